// File: rtl/fft_pkg.sv
// Shared defaults, drain-state encoding and the stereo-to-mono mix used by the
// FFT frame loader.
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_N_2   = 5;
  localparam int FFT_IN_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } drain_state_e;

  // Top WIDTH bits of the IN_W+1 bit sum, i.e. the truncated average.
  function automatic logic [FFT_WIDTH-1:0] mix_sample(
    input logic [FFT_IN_W-1:0] l,
    input logic [FFT_IN_W-1:0] r
  );
    logic [FFT_IN_W:0] sum;
    sum = {l[FFT_IN_W-1], l} + {r[FFT_IN_W-1], r};
    return sum[FFT_IN_W -: FFT_WIDTH];
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port, one registered read port, no reset on
// the array or read register so it maps onto block RAM.
module frame_bank_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Mixes stereo I2S samples to mono, collects them into ping-pong frames and
// bursts each full frame into the FFT core, then tracks the core until done.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N_2   = FFT_N_2,
  parameter int IN_W  = FFT_IN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [IN_W-1:0]  sample_l,
  input  logic [IN_W-1:0]  sample_r,
  output logic             fft_load,
  output logic [WIDTH-1:0] fft_rd,
  output logic             fft_start,
  input  logic             fft_done,
  output logic             overrun,
  output logic             busy
);

  localparam logic [N_2-1:0] PTR_LAST = '1;

  drain_state_e     state_q, state_d;
  logic             fill_bank_q, fill_bank_d;
  logic             drain_bank_q, drain_bank_d;
  logic [N_2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [N_2-1:0]   rd_ptr_q, rd_ptr_d;
  logic             overrun_q, overrun_d;
  logic             fft_load_q, fft_load_d;
  logic [WIDTH-1:0] fft_rd_q, fft_rd_d;
  logic             fft_start_q, fft_start_d;
  logic             busy_q, busy_d;

  logic             frame_full;
  logic             accept;
  logic             handoff;
  logic [WIDTH-1:0] mix_val;
  logic [WIDTH-1:0] ram_rd_data;

  generate
    if (IN_W == FFT_IN_W && WIDTH == FFT_WIDTH) begin : g_mix_pkg
      assign mix_val = mix_sample(sample_l, sample_r);
    end else begin : g_mix_generic
      logic [IN_W:0] mix_sum;
      assign mix_sum = {sample_l[IN_W-1], sample_l} + {sample_r[IN_W-1], sample_r};
      assign mix_val = mix_sum[IN_W -: WIDTH];
    end
  endgenerate

  // Read address follows the next-state pointer so RAM data lands in the
  // same cycle the FSM sits on that sample.
  frame_bank_ram #(
    .WIDTH (WIDTH),
    .AW    (N_2 + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (sample_valid),
    .wr_addr ({fill_bank_q, wr_ptr_q}),
    .wr_data (mix_val),
    .rd_addr ({drain_bank_d, rd_ptr_d}),
    .rd_data (ram_rd_data)
  );

  // A release on this edge frees the drain side in time to take the frame.
  always_comb begin
    frame_full  = sample_valid && (wr_ptr_q == PTR_LAST);
    accept      = (state_q == ST_IDLE) || ((state_q == ST_WAIT_LO) && !fft_done);
    handoff     = frame_full && accept;
    wr_ptr_d    = sample_valid ? wr_ptr_q + N_2'(1) : wr_ptr_q;
    fill_bank_d = fill_bank_q ^ handoff;
    overrun_d   = overrun_q | (frame_full & ~accept);
  end

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    drain_bank_d = drain_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (handoff) begin
          state_d      = ST_LOAD;
          rd_ptr_d     = '0;
          drain_bank_d = fill_bank_q;
        end
      end
      ST_LOAD: begin
        rd_ptr_d = rd_ptr_q + N_2'(1);
        if (rd_ptr_q == PTR_LAST) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP:     state_d = ST_START;
      ST_START:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (fft_done) begin
          state_d = ST_WAIT_HI == state_q ? ST_WAIT_LO : state_q;
        end
      end
      ST_WAIT_LO: begin
        if (!fft_done) begin
          if (handoff) begin
            state_d      = ST_LOAD;
            rd_ptr_d     = '0;
            drain_bank_d = fill_bank_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default:    state_d = ST_IDLE;
    endcase

    fft_load_d  = (state_q == ST_LOAD);
    fft_rd_d    = fft_load_d ? ram_rd_data : '0;
    fft_start_d = (state_q == ST_START);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overrun_q    <= 1'b0;
      fft_load_q   <= 1'b0;
      fft_rd_q     <= '0;
      fft_start_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_bank_q  <= fill_bank_d;
      drain_bank_q <= drain_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overrun_q    <= overrun_d;
      fft_load_q   <= fft_load_d;
      fft_rd_q     <= fft_rd_d;
      fft_start_q  <= fft_start_d;
      busy_q       <= busy_d;
    end
  end

  assign fft_load  = fft_load_q;
  assign fft_rd    = fft_rd_q;
  assign fft_start = fft_start_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: stimulus queues expected loads, a
// negedge monitor pops and compares them and checks burst/start timing.
module tb_fft_frame_loader;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_l = '0;
  logic [23:0] sample_r = '0;
  logic        fft_done = 1'b0;
  logic        fft_load;
  logic [15:0] fft_rd;
  logic        fft_start;
  logic        overrun;
  logic        busy;

  always #5 clk = ~clk;

  fft_frame_loader dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .fft_load     (fft_load),
    .fft_rd       (fft_rd),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .overrun      (overrun),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int cyc = 0;
  int last_load_cyc = -100;
  int start_cnt = 0;
  int load_total = 0;
  int run_len = 0;
  int burst_cnt = 0;
  int burst_start_cyc = 0;
  int done_fall_cyc = 0;
  logic prev_load = 1'b0;

  logic [23:0] mix_l [6];
  logic [23:0] mix_r [6];
  logic [15:0] mix_e [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one line per load transaction, compared against the queue head.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_load = 1'b0;
      run_len   = 0;
    end else begin
      if (fft_load) begin
        check("busy_in_load", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("load_with_empty_queue", 32'(fft_load), 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          $display("load idx=%0d rd=%04h exp=%04h", run_len, fft_rd, e);
          check("fft_rd", 32'(fft_rd), 32'(e));
        end
        if (!prev_load) begin
          burst_cnt++;
          burst_start_cyc = cyc;
        end
        run_len++;
        last_load_cyc = cyc;
        load_total++;
      end else begin
        check("fft_rd_idle", 32'(fft_rd), 32'd0);
        if (prev_load) begin
          check("burst_len", 32'(run_len), 32'(N));
          run_len = 0;
        end
      end
      if (fft_start) begin
        $display("start after last load gap=%0d", cyc - last_load_cyc);
        check("start_gap", 32'(cyc - last_load_cyc), 32'd2);
        start_cnt++;
      end
      prev_load = fft_load;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, input int gap);
    sample_valid = 1'b1;
    sample_l     = l;
    sample_r     = r;
    tick();
    sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_start(input int prev, input string name);
    int n = 0;
    while (start_cnt <= prev && n < 500) begin
      tick();
      n++;
    end
    check(name, 32'(start_cnt > prev), 32'd1);
  endtask

  task automatic release_fft();
    fft_done = 1'b1;
    tick();
    tick();
    fft_done = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int prev;
    int bc;
    int base;
    int n;

    mix_l = '{24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h000200, 24'hFFFE00, 24'hFFFC00};
    mix_r = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h000000, 24'h000000, 24'h000100};
    mix_e = '{16'h8000,   16'h7FFF,   16'hFFFF,   16'h0001,   16'hFFFF,   16'hFFFE};

    // Reset with sample_valid toggling
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample_valid = i[0];
      @(negedge clk);
      check("reset_outputs", 32'({fft_load, fft_start, busy, overrun, fft_rd}), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample_valid = 1'b0;
    tick();
    check("overrun_after_reset", 32'(overrun), 32'd0);
    check("busy_after_reset", 32'(busy), 32'd0);

    // Ramp frame, one strobe every 4 cycles
    prev = start_cnt;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(16'(k));
      send(24'(k << 8), 24'(k << 8), 3);
    end
    wait_start(prev, "ramp_start");
    check("ramp_busy", 32'(busy), 32'd1);
    check("ramp_drained", 32'(exp_q.size()), 32'd0);
    check("ramp_bursts", 32'(burst_cnt), 32'd1);

    // Mix arithmetic
    release_fft();
    check("idle_busy", 32'(busy), 32'd0);
    prev = start_cnt;
    for (int k = 0; k < N; k++) begin
      if (k < 6) begin
        exp_q.push_back(mix_e[k]);
        send(mix_l[k], mix_r[k], 1);
      end else begin
        exp_q.push_back(16'h0000);
        send(24'h000000, 24'h000000, 1);
      end
    end
    wait_start(prev, "mix_start");
    check("mix_drained", 32'(exp_q.size()), 32'd0);

    // Ping-pong: last sample lands on the cycle fft_done first reads low
    prev = start_cnt;
    for (int i = 0; i <= N; i++) begin
      fft_done = (i < N);
      if (i == N) done_fall_cyc = cyc + 1;
      if (i >= 1) begin
        exp_q.push_back(16'(100 + i - 1));
        sample_valid = 1'b1;
        sample_l     = 24'((99 + i) << 8);
        sample_r     = 24'((99 + i) << 8);
      end else begin
        sample_valid = 1'b0;
      end
      tick();
    end
    sample_valid = 1'b0;
    fft_done = 1'b0;
    wait_start(prev, "pingpong_start");
    check("pingpong_latency", 32'((burst_start_cyc - done_fall_cyc) <= 2), 32'd1);
    check("pingpong_overrun", 32'(overrun), 32'd0);
    check("pingpong_drained", 32'(exp_q.size()), 32'd0);

    // Overrun: drain side held in WAIT_HI
    for (int k = 0; k < 2 * N; k++) begin
      send(24'((200 + k) << 8), 24'((200 + k) << 8), 0);
      if (k == N - 2) check("overrun_before_wrap", 32'(overrun), 32'd0);
      if (k == N - 1) check("overrun_set", 32'(overrun), 32'd1);
    end
    check("overrun_sticky", 32'(overrun), 32'd1);
    bc = burst_cnt;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(16'(300 + k));
      send(24'((300 + k) << 8), 24'((300 + k) << 8), 0);
    end
    repeat (5) tick();
    check("no_burst_while_busy", 32'(burst_cnt), 32'(bc));
    fft_done = 1'b1;
    repeat (3) tick();
    fft_done = 1'b0;
    tick();
    check("no_burst_after_release", 32'(burst_cnt), 32'(bc));
    prev = start_cnt;
    for (int k = 16; k < N; k++) begin
      exp_q.push_back(16'(300 + k));
      send(24'((300 + k) << 8), 24'((300 + k) << 8), 0);
    end
    wait_start(prev, "overrun_frame_start");
    check("overrun_frame_drained", 32'(exp_q.size()), 32'd0);
    check("overrun_still_set", 32'(overrun), 32'd1);

    // Mid-load reset
    release_fft();
    base = load_total;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(16'(400 + k));
      send(24'((400 + k) << 8), 24'((400 + k) << 8), 0);
    end
    n = 0;
    while (load_total < base + 10 && n < 200) begin
      tick();
      n++;
    end
    check("midload_reached", 32'(load_total >= base + 10), 32'd1);
    check("midload_loading", 32'(fft_load), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_async_load", 32'(fft_load), 32'd0);
    check("reset_async_rd", 32'(fft_rd), 32'd0);
    check("reset_clears_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_busy", 32'(busy), 32'd0);

    prev = start_cnt;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(16'(500 + k));
      send(24'((500 + k) << 8), 24'((500 + k) << 8), 1);
    end
    wait_start(prev, "fresh_start");
    check("fresh_drained", 32'(exp_q.size()), 32'd0);
    check("fresh_overrun", 32'(overrun), 32'd0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
